countdown_sequencer: RTL and testbench

//  Mode-4 controller for the MM:SS countdown timer. Sequences configuration (minutes, then seconds
//  via push buttons), start/pause/resume, the 1 Hz decrement, and a bounded alarm phase.

---
 rtl/countdown_pkg.sv | 27 ++
 rtl/countdown_sequencer_if.sv | 26 ++
 rtl/countdown_sequencer_counter.sv | 35 +++
 rtl/countdown_sequencer.sv | 159 +++++++++++++++
 tb/tb_countdown_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Shared types and widths for the MM:SS countdown timer controller.
package countdown_pkg;

    localparam int unsigned MIN_W   = 7;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned SEC_MAX = 59;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_MIN = 3'd1,
        SET_SEC = 3'd2,
        RUN     = 3'd3,
        PAUSE   = 3'd4,
        ALARM   = 3'd5
    } state_t;

    // States in which the display shows the live count rather than the set value
    function automatic logic shows_count(input state_t s);
        return (s == RUN) || (s == PAUSE) || (s == ALARM);
    endfunction

    // States in which the 1 Hz prescaler runs
    function automatic logic is_timed(input state_t s);
        return (s == RUN) || (s == ALARM);
    endfunction

endpackage

// File: rtl/countdown_sequencer_if.sv
// Button inputs and display/status outputs of the countdown controller.
interface countdown_sequencer_if;
    import countdown_pkg::*;

    logic             enable;
    logic             btn_mode;
    logic             btn_inc;
    logic             btn_start;
    logic [MIN_W-1:0] minutos_o;
    logic [SEC_W-1:0] segundos_o;
    logic [2:0]       state_o;
    logic             configuration;
    logic             running;
    logic             alarm;

    modport master (
        output enable, btn_mode, btn_inc, btn_start,
        input  minutos_o, segundos_o, state_o, configuration, running, alarm
    );

    modport slave (
        input  enable, btn_mode, btn_inc, btn_start,
        output minutos_o, segundos_o, state_o, configuration, running, alarm
    );

endinterface

// File: rtl/countdown_sequencer_counter.sv
// MM:SS down-counter with parallel load; load wins over decrement.
module mmss_down_counter
    import countdown_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [SEC_W-1:0] load_sec,
    input  logic             dec,
    output logic [MIN_W-1:0] min,
    output logic [SEC_W-1:0] sec,
    output logic             is_one
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min <= '0;
            sec <= '0;
        end else if (load) begin
            min <= load_min;
            sec <= load_sec;
        end else if (dec) begin
            if (sec != '0) begin
                sec <= SEC_W'(sec - SEC_W'(1));
            end else begin
                min <= MIN_W'(min - MIN_W'(1));
                sec <= SEC_W'(SEC_MAX);
            end
        end
    end

    assign is_one = (min == '0) && (sec == SEC_W'(1));

endmodule

// File: rtl/countdown_sequencer.sv
// Mode-4 countdown controller: configuration, start/pause, 1 Hz countdown and bounded alarm.
module countdown_sequencer
    import countdown_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned ALARM_SECS = 10,
    parameter int unsigned MAX_MIN    = 99
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_sequencer_if.slave  bus
);

    localparam int unsigned PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned AC_W = $clog2(ALARM_SECS + 1);

    state_t           state, state_next;
    logic             mode_q, inc_q, start_q;
    logic             mode_p, inc_p, start_p;
    logic [PS_W-1:0]  prescaler;
    logic             tick;
    logic [AC_W-1:0]  alarm_cnt;
    logic             alarm_last;
    logic [MIN_W-1:0] set_min, cnt_min;
    logic [SEC_W-1:0] set_sec, cnt_sec;
    logic             cnt_is_one;
    logic             cnt_load, cnt_dec, set_min_inc, set_sec_inc, alarm_inc;

    assign mode_p  = bus.btn_mode  & ~mode_q;
    assign inc_p   = bus.btn_inc   & ~inc_q;
    assign start_p = bus.btn_start & ~start_q;

    assign tick       = is_timed(state) && (prescaler == PS_W'(CLK_HZ - 1));
    assign alarm_last = (AC_W'(alarm_cnt + AC_W'(1)) == AC_W'(ALARM_SECS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            inc_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_next;
            mode_q  <= bus.btn_mode;
            inc_q   <= bus.btn_inc;
            start_q <= bus.btn_start;
        end
    end

    // A press that the current state ignores does not block lower-priority events
    always_comb begin
        state_next  = state;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        set_min_inc = 1'b0;
        set_sec_inc = 1'b0;
        alarm_inc   = 1'b0;
        if (!bus.enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_p && ({set_min, set_sec} != '0)) begin
                        state_next = RUN;
                        cnt_load   = 1'b1;
                    end else if (mode_p) begin
                        state_next = SET_MIN;
                    end
                end
                SET_MIN: begin
                    if (mode_p)      state_next  = SET_SEC;
                    else if (inc_p)  set_min_inc = 1'b1;
                end
                SET_SEC: begin
                    if (mode_p)      state_next  = IDLE;
                    else if (inc_p)  set_sec_inc = 1'b1;
                end
                RUN: begin
                    if (start_p) begin
                        state_next = PAUSE;
                    end else if (tick) begin
                        cnt_dec = 1'b1;
                        if (cnt_is_one) state_next = ALARM;
                    end
                end
                PAUSE: begin
                    if (start_p) begin
                        state_next = RUN;
                    end else if (mode_p) begin
                        state_next = IDLE;
                        cnt_load   = 1'b1;
                    end
                end
                ALARM: begin
                    if (start_p || mode_p || (tick && alarm_last)) begin
                        state_next = IDLE;
                        cnt_load   = 1'b1;
                    end else if (tick) begin
                        alarm_inc = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Prescaler restarts from 0 on every entry to a timed state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (is_timed(state_next) && (state_next == state) && !tick) begin
            prescaler <= PS_W'(prescaler + PS_W'(1));
        end else begin
            prescaler <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_cnt <= '0;
        end else if (state_next != ALARM) begin
            alarm_cnt <= '0;
        end else if (alarm_inc) begin
            alarm_cnt <= AC_W'(alarm_cnt + AC_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_min <= '0;
            set_sec <= '0;
        end else begin
            if (set_min_inc)
                set_min <= (set_min == MIN_W'(MAX_MIN)) ? '0 : MIN_W'(set_min + MIN_W'(1));
            if (set_sec_inc)
                set_sec <= (set_sec == SEC_W'(SEC_MAX)) ? '0 : SEC_W'(set_sec + SEC_W'(1));
        end
    end

    mmss_down_counter u_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (cnt_load),
        .load_min (set_min),
        .load_sec (set_sec),
        .dec      (cnt_dec),
        .min      (cnt_min),
        .sec      (cnt_sec),
        .is_one   (cnt_is_one)
    );

    assign bus.minutos_o     = shows_count(state) ? cnt_min : set_min;
    assign bus.segundos_o    = shows_count(state) ? cnt_sec : set_sec;
    assign bus.state_o       = state;
    assign bus.configuration = (state == SET_MIN) || (state == SET_SEC);
    assign bus.running       = (state == RUN);
    assign bus.alarm         = (state == ALARM);

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer: stimulus queues timestamped expectations, monitor compares.
module tb_countdown_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    countdown_sequencer_if bus ();

    countdown_sequencer #(
        .CLK_HZ     (4),
        .ALARM_SECS (3),
        .MAX_MIN    (99)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    due;
        string name;
        int    mn;
        int    sc;
        int    st;
    } exp_t;

    exp_t q[$];

    task automatic expect_now(input string name, input int mn, input int sc, input int st);
        exp_t e;
        e.due  = cyc;
        e.name = name;
        e.mn   = mn;
        e.sc   = sc;
        e.st   = st;
        q.push_back(e);
    endtask

    // Monitor: samples outputs just after the falling edge
    initial begin
        exp_t e;
        int   cfg_e, run_e, alm_e;
        forever begin
            @(negedge clk);
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                cfg_e = (e.st == 1 || e.st == 2) ? 1 : 0;
                run_e = (e.st == 3) ? 1 : 0;
                alm_e = (e.st == 5) ? 1 : 0;
                if (e.due != cyc) begin
                    errors++;
                    $display("FAIL %s: expectation stale (due cycle %0d, now %0d)", e.name, e.due, cyc);
                end else if (int'(bus.minutos_o) != e.mn || int'(bus.segundos_o) != e.sc ||
                             int'(bus.state_o) != e.st || int'(bus.configuration) != cfg_e ||
                             int'(bus.running) != run_e || int'(bus.alarm) != alm_e) begin
                    errors++;
                    $display("FAIL %s: got %0d:%0d st=%0d cfg=%0d run=%0d alm=%0d, expected %0d:%0d st=%0d cfg=%0d run=%0d alm=%0d",
                             e.name, bus.minutos_o, bus.segundos_o, bus.state_o, bus.configuration,
                             bus.running, bus.alarm, e.mn, e.sc, e.st, cfg_e, run_e, alm_e);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 mode, 1 inc, 2 start, 3 start+mode; returns one cycle after the acting edge
    task automatic press(input int which);
        bus.btn_mode  = (which == 0 || which == 3);
        bus.btn_inc   = (which == 1);
        bus.btn_start = (which == 2 || which == 3);
        @(negedge clk);
        bus.btn_mode  = 1'b0;
        bus.btn_inc   = 1'b0;
        bus.btn_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_n(input int which, input int n);
        for (int i = 0; i < n; i++) press(which);
    endtask

    initial begin
        bus.enable    = 1'b1;
        bus.btn_mode  = 1'b0;
        bus.btn_inc   = 1'b0;
        bus.btn_start = 1'b0;

        // 1. reset and configuration, seconds wrap
        @(negedge clk);
        expect_now("reset_state", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(1);
        press(0);
        expect_now("enter_set_min", 0, 0, 1);
        press_n(1, 3);
        expect_now("set_min_3", 3, 0, 1);
        press(0);
        press_n(1, 59);
        expect_now("set_sec_59", 3, 59, 2);
        press(1);
        expect_now("set_sec_wrap", 3, 0, 2);
        press(0);
        expect_now("idle_0300", 3, 0, 0);

        // 2. minute wrap and start at 00:00
        press(0);
        press_n(1, 96);
        expect_now("set_min_99", 99, 0, 1);
        press(1);
        expect_now("set_min_wrap", 0, 0, 1);
        press(0);
        press(0);
        expect_now("idle_0000", 0, 0, 0);
        press(2);
        expect_now("start_zero_stays", 0, 0, 0);

        // 3. countdown 00:02 into alarm and auto-return
        press(0);
        press(0);
        press_n(1, 2);
        press(0);
        expect_now("idle_0002", 0, 2, 0);
        press(2);
        expect_now("run_start", 0, 2, 3);
        wait_cyc(2);
        expect_now("run_before_tick", 0, 2, 3);
        wait_cyc(1);
        expect_now("run_first_tick", 0, 1, 3);
        wait_cyc(3);
        expect_now("run_before_zero", 0, 1, 3);
        wait_cyc(1);
        expect_now("alarm_entry", 0, 0, 5);
        wait_cyc(11);
        expect_now("alarm_last_cycle", 0, 0, 5);
        wait_cyc(1);
        expect_now("alarm_timeout_idle", 0, 2, 0);

        // 4. minute borrow, pause and resume timing
        press(0);
        press(1);
        press(0);
        press_n(1, 58);
        press(0);
        expect_now("idle_0100", 1, 0, 0);
        press(2);
        wait_cyc(3);
        expect_now("borrow_0059", 0, 59, 3);
        press(2);
        expect_now("paused", 0, 59, 4);
        wait_cyc(20);
        expect_now("pause_hold", 0, 59, 4);
        press(2);
        expect_now("resumed", 0, 59, 3);
        wait_cyc(2);
        expect_now("resume_before_tick", 0, 59, 3);
        wait_cyc(1);
        expect_now("resume_tick", 0, 58, 3);

        // 5. simultaneous start+mode, then enable drop
        press(3);
        expect_now("start_beats_mode", 0, 58, 4);
        press(2);
        expect_now("resume_again", 0, 58, 3);
        bus.enable = 1'b0;
        @(negedge clk);
        expect_now("enable_low_idle", 1, 0, 0);
        bus.enable = 1'b1;
        @(negedge clk);

        // 6. async reset in ALARM
        press(0);
        press_n(1, 99);
        expect_now("set_min_wrap_from_1", 0, 0, 1);
        press(0);
        press(1);
        press(0);
        expect_now("idle_0001", 0, 1, 0);
        press(2);
        wait_cyc(3);
        expect_now("alarm_from_0001", 0, 0, 5);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        expect_now("async_reset_alarm", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #2;
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked", q.size());
            errors += q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
